// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM among N_REQ draw units.
// Define SPRITE_ARB_PRIO0_EN to give requester 0 absolute priority over the rest.
module sprite_rom_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 5,
    parameter int ROM_LAT = 1
) (
    input  logic                       vga_clk,
    input  logic                       reset_n,
    input  logic                       arb_en,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    output logic [N_REQ-1:0]           gnt,
    output logic [ADDR_W-1:0]          rom_address,
    output logic                       rom_rd,
    input  logic [DATA_W-1:0]          rom_q,
    output logic                       rd_valid,
    output logic [$clog2(N_REQ)-1:0]   rd_id,
    output logic [DATA_W-1:0]          rd_data
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W-1:0] ONE  = PTR_W'(1);
`ifdef SPRITE_ARB_PRIO0_EN
    localparam logic [PTR_W-1:0] PTR_RST = ONE;
`else
    localparam logic [PTR_W-1:0] PTR_RST = '0;
`endif

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [PTR_W-1:0]         ptr;
    logic [PTR_W-1:0]         ptr_nxt;
    logic [PTR_W-1:0]         gnt_idx;
    logic [PTR_W-1:0]         issue_id;
    logic [ADDR_W-1:0]        sel_addr;
    logic                     transfer;
    logic [0:0]               state;
    logic [ROM_LAT-1:0]       vpipe;
    logic [ROM_LAT-1:0]       vshift;
    logic [ROM_LAT*PTR_W-1:0] idpipe;
    logic [ROM_LAT*PTR_W-1:0] idshift;

    always_comb begin
        logic [PTR_W-1:0] cand;
        logic             found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        if (arb_en) begin
`ifdef SPRITE_ARB_PRIO0_EN
            if (req[0]) begin
                gnt[0] = 1'b1;
                found  = 1'b1;
            end
            // Secondary pointer only ranges over 1..N_REQ-1.
            for (int unsigned k = 0; k < N_REQ - 1; k++) begin
                cand = PTR_W'(1 + (32'(ptr) - 1 + k) % (N_REQ - 1));
                if (!found && req[cand]) begin
                    found     = 1'b1;
                    gnt[cand] = 1'b1;
                    gnt_idx   = cand;
                end
            end
`else
            for (int unsigned k = 0; k < N_REQ; k++) begin
                cand = PTR_W'((32'(ptr) + k) % N_REQ);
                if (!found && req[cand]) begin
                    found     = 1'b1;
                    gnt[cand] = 1'b1;
                    gnt_idx   = cand;
                end
            end
`endif
        end
    end

    assign transfer = |gnt;
    assign sel_addr = req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];

    always_comb begin
        ptr_nxt = ptr;
`ifdef SPRITE_ARB_PRIO0_EN
        if (transfer && gnt_idx != '0)
            ptr_nxt = (gnt_idx == LAST) ? ONE : gnt_idx + ONE;
`else
        if (transfer)
            ptr_nxt = (gnt_idx == LAST) ? '0 : gnt_idx + ONE;
`endif
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr         <= PTR_RST;
            rom_address <= '0;
            rom_rd      <= 1'b0;
            issue_id    <= '0;
            state       <= IDLE;
        end else begin
            ptr    <= ptr_nxt;
            rom_rd <= transfer;
            if (transfer) begin
                rom_address <= sel_addr;
                issue_id    <= gnt_idx;
            end
            state <= (transfer || rom_rd || (|vpipe)) ? ACTIVE : IDLE;
        end
    end

    generate
        if (ROM_LAT == 1) begin : g_lat1
            assign vshift  = rom_rd;
            assign idshift = issue_id;
        end else begin : g_latn
            assign vshift  = {vpipe[ROM_LAT-2:0], rom_rd};
            assign idshift = {idpipe[(ROM_LAT-1)*PTR_W-1:0], issue_id};
        end
    endgenerate

    // In IDLE the pipeline is already empty and rom_rd is low, so holding equals shifting.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            vpipe  <= '0;
            idpipe <= '0;
        end else if (state == ACTIVE) begin
            vpipe  <= vshift;
            idpipe <= idshift;
        end
    end

    assign rd_valid = vpipe[ROM_LAT-1];
    assign rd_id    = idpipe[ROM_LAT*PTR_W-1 -: PTR_W];
    assign rd_data  = rom_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a ROM model and return-data scoreboard.
module tb_sprite_rom_arbiter;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic        arb_en;
    logic [3:0]  req;
    logic [35:0] req_addr;
    logic [3:0]  gnt;
    logic [8:0]  rom_address;
    logic        rom_rd;
    logic [4:0]  rom_q;
    logic        rd_valid;
    logic [1:0]  rd_id;
    logic [4:0]  rd_data;

    typedef struct {
        logic [1:0] id;
        logic [4:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] rom_mem [512];
    logic [8:0] addr_tab [4];
    int         tests = 0;
    int         fails = 0;

    sprite_rom_arbiter #(
        .N_REQ(4), .ADDR_W(9), .DATA_W(5), .ROM_LAT(1)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .arb_en(arb_en), .req(req),
        .req_addr(req_addr), .gnt(gnt), .rom_address(rom_address), .rom_rd(rom_rd),
        .rom_q(rom_q), .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

    always @(negedge vga_clk) begin
        if (reset_n === 1'b1 && rd_valid === 1'b1) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL sb_unexpected: rd_valid with id=%0d data=%0h, expected no return", rd_id, rd_data);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                tests++;
                assert ({rd_id, rd_data} === {e.id, e.data}) else begin
                    fails++;
                    $error("FAIL sb_return: id=%0d data=%0h, expected id=%0d data=%0h", rd_id, rd_data, e.id, e.data);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic en, input logic [3:0] exp_g, input string tag);
        @(posedge vga_clk);
        #1;
        req    = r;
        arb_en = en;
        @(negedge vga_clk);
        tests++;
        assert (gnt === exp_g) else begin
            fails++;
            $error("FAIL %s: gnt=%b expected %b", tag, gnt, exp_g);
        end
        for (int i = 0; i < 4; i++)
            if (exp_g[i]) sb.push_back('{id: 2'(i), data: rom_mem[addr_tab[i]]});
    endtask

    initial begin
        logic [3:0] e;
        for (int i = 0; i < 512; i++) rom_mem[i] = 5'(i * 7 + 3);
        rom_mem[9'h05A] = 5'h13;
        addr_tab[0] = 9'h011;
        addr_tab[1] = 9'h122;
        addr_tab[2] = 9'h05A;
        addr_tab[3] = 9'h1F3;
        req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
        reset_n  = 1'b0;
        arb_en   = 1'b1;
        req      = 4'b0000;

        #12;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rom_rd", 32'(rom_rd), 0);
        chk("rst_rom_address", 32'(rom_address), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_id", 32'(rd_id), 0);
        reset_n = 1'b1;

        // Fairness from reset
        for (int c = 0; c < 8; c++) begin
`ifdef SPRITE_ARB_PRIO0_EN
            e = 4'b0001;
`else
            e = 4'b0001 << (c % 4);
`endif
            step(4'b1111, 1'b1, e, "fair");
        end
        for (int c = 0; c < 3; c++) step(4'b0000, 1'b1, 4'b0000, "idle");

        // Latency
        step(4'b0100, 1'b1, 4'b0100, "lat_gnt");
        @(posedge vga_clk);
        #1;
        req = 4'b0000;
        @(negedge vga_clk);
        chk("lat_rom_rd", 32'(rom_rd), 1);
        chk("lat_rom_address", 32'(rom_address), 32'h05A);
        @(posedge vga_clk);
        @(negedge vga_clk);
        chk("lat_rd_valid", 32'(rd_valid), 1);
        chk("lat_rd_id", 32'(rd_id), 2);
        chk("lat_rd_data", 32'(rd_data), 32'h13);
        step(4'b0000, 1'b1, 4'b0000, "idle");

        // Sparse requests from ptr=3, then single requester at the top index
`ifdef SPRITE_ARB_PRIO0_EN
        step(4'b0101, 1'b1, 4'b0001, "sparse_a");
        step(4'b0101, 1'b1, 4'b0001, "sparse_b");
        step(4'b0101, 1'b1, 4'b0001, "sparse_c");
`else
        step(4'b0101, 1'b1, 4'b0001, "sparse_a");
        step(4'b0101, 1'b1, 4'b0100, "sparse_b");
        step(4'b0101, 1'b1, 4'b0001, "sparse_c");
`endif
        for (int c = 0; c < 3; c++) step(4'b1000, 1'b1, 4'b1000, "single3");
        step(4'b1111, 1'b1, 4'b0001, "wrap_ptr0");

        // Pause with one read in flight
        step(4'b0010, 1'b1, 4'b0010, "pause_pre");
        step(4'b0010, 1'b0, 4'b0000, "pause_lo1");
        step(4'b0010, 1'b0, 4'b0000, "pause_lo2");
        chk("pause_inflight_valid", 32'(rd_valid), 1);
        chk("pause_inflight_id", 32'(rd_id), 1);
        step(4'b0010, 1'b0, 4'b0000, "pause_lo3");
        step(4'b0010, 1'b1, 4'b0010, "pause_resume");
        for (int c = 0; c < 3; c++) step(4'b0000, 1'b1, 4'b0000, "idle");

        // Reset with two reads in flight
`ifdef SPRITE_ARB_PRIO0_EN
        step(4'b1111, 1'b1, 4'b0001, "burst_a");
        step(4'b1111, 1'b1, 4'b0001, "burst_b");
`else
        step(4'b1111, 1'b1, 4'b0100, "burst_a");
        step(4'b1111, 1'b1, 4'b1000, "burst_b");
`endif
        @(posedge vga_clk);
        #1;
        reset_n = 1'b0;
        req     = 4'b0000;
        sb.delete();
        #1;
        chk("midrst_gnt", 32'(gnt), 0);
        chk("midrst_rom_rd", 32'(rom_rd), 0);
        chk("midrst_rom_address", 32'(rom_address), 0);
        chk("midrst_rd_valid", 32'(rd_valid), 0);
        chk("midrst_rd_id", 32'(rd_id), 0);
        @(negedge vga_clk);
        #2;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(4'b0000, 1'b1, 4'b0000, "post_rst");
            chk("post_rst_rd_valid", 32'(rd_valid), 0);
        end

        // Priority comparison from a fresh pointer
`ifdef SPRITE_ARB_PRIO0_EN
        step(4'b1111, 1'b1, 4'b0001, "prio_a");
        step(4'b1111, 1'b1, 4'b0001, "prio_b");
        step(4'b1111, 1'b1, 4'b0001, "prio_c");
        step(4'b1110, 1'b1, 4'b0010, "prio_d");
        step(4'b1110, 1'b1, 4'b0100, "prio_e");
        step(4'b1110, 1'b1, 4'b1000, "prio_f");
`else
        step(4'b1111, 1'b1, 4'b0001, "prio_a");
        step(4'b1111, 1'b1, 4'b0010, "prio_b");
        step(4'b1111, 1'b1, 4'b0100, "prio_c");
        step(4'b1110, 1'b1, 4'b1000, "prio_d");
        step(4'b1110, 1'b1, 4'b0010, "prio_e");
        step(4'b1110, 1'b1, 4'b0100, "prio_f");
`endif
        for (int c = 0; c < 3; c++) step(4'b0000, 1'b1, 4'b0000, "idle");
        chk("sb_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
